// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared pellet-scoring types and constants
package pacman_pkg;

  localparam int          NUM_PELLETS_C = 96;
  localparam logic [15:0] MAX_SCORE_C   = 16'h9999;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } score_state_t;

endpackage

// File: rtl/pellet_score_bcd_sat_add.sv
// rtl/pellet_score_bcd_sat_add.sv - four-digit BCD adder saturating at 9999
module bcd_sat_add
  import pacman_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  always_comb begin
    logic       carry;
    logic [4:0] dsum;
    logic [4:0] dadj;
    logic [15:0] raw;
    bcd_digit_t digit;
    carry = 1'b0;
    dsum  = '0;
    dadj  = '0;
    raw   = '0;
    digit = '0;
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, carry};
      // A digit sum above nine wraps by ten and carries into the next digit.
      if (dsum > 5'd9) begin
        dadj  = dsum - 5'd10;
        carry = 1'b1;
      end else begin
        dadj  = dsum;
        carry = 1'b0;
      end
      digit = dadj[3:0];
      raw[4*i +: 4] = digit;
    end
    sum_o = carry ? MAX_SCORE_C : raw;
  end

endmodule

// File: rtl/pellet_score.sv
// rtl/pellet_score.sv - per-frame pellet bitmap scan crediting score, pellet count and lives
module pellet_score
  import pacman_pkg::*;
#(
  parameter int          NUM_PELLETS = NUM_PELLETS_C,
  parameter logic [15:0] PELLET_PTS  = 16'h0010,
  parameter int          START_LIVES = 3
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic [NUM_PELLETS-1:0] array,
  input  logic                   over,
  input  logic                   level_clear,
  input  logic                   new_game,
  output logic [15:0]            score_bcd,
  output logic [6:0]             pellets,
  output logic [1:0]             lives,
  output logic                   dead,
  output logic                   busy,
  output logic                   scan_done
);

  localparam int IDX_W = $clog2(NUM_PELLETS);

  score_state_t           state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [2:0]             frame_sync_q, over_sync_q;
  logic                   frame_rise_q, over_rise_q;
  logic [NUM_PELLETS-1:0] snap_q, snap_d;
  logic [15:0]            score_q, score_d, score_sum;
  logic [6:0]             pellets_q, pellets_d;
  logic [1:0]             lives_q, lives_d;
  logic                   dead_q, dead_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   credit;

  // Two synchronizer flops, a third holding the previous level, then a registered rise pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_sync_q <= '0;
      over_sync_q  <= '0;
      frame_rise_q <= 1'b0;
      over_rise_q  <= 1'b0;
    end else begin
      frame_sync_q <= {frame_sync_q[1:0], frame_clk};
      over_sync_q  <= {over_sync_q[1:0], over};
      frame_rise_q <= frame_sync_q[1] & ~frame_sync_q[2];
      over_rise_q  <= over_sync_q[1] & ~over_sync_q[2];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (new_game || level_clear) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_rise_q) begin
            state_d = SCAN;
            idx_d   = '0;
          end
        end
        SCAN: begin
          if (idx_q == IDX_W'(NUM_PELLETS - 1)) state_d = DONE;
          else                                   idx_d   = idx_q + 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  bcd_sat_add u_add (
    .a_i   (score_q),
    .b_i   (PELLET_PTS),
    .sum_o (score_sum)
  );

  assign credit = (state_q == SCAN) && array[idx_q] && !snap_q[idx_q];

  always_comb begin
    snap_d    = snap_q;
    score_d   = score_q;
    pellets_d = pellets_q;
    lives_d   = lives_q;
    if (new_game) begin
      snap_d    = '0;
      score_d   = '0;
      pellets_d = '0;
      lives_d   = 2'(START_LIVES);
    end else begin
      if (level_clear) begin
        snap_d    = '0;
        pellets_d = '0;
      end else if (credit) begin
        snap_d[idx_q] = 1'b1;
        score_d       = score_sum;
        if (pellets_q < 7'(NUM_PELLETS)) pellets_d = pellets_q + 7'd1;
      end
      if (over_rise_q && lives_q != 2'd0) lives_d = lives_q - 2'd1;
    end
    dead_d = (lives_d == 2'd0);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      snap_q    <= '0;
      score_q   <= '0;
      pellets_q <= '0;
      lives_q   <= 2'(START_LIVES);
      dead_q    <= 1'b0;
    end else begin
      snap_q    <= snap_d;
      score_q   <= score_d;
      pellets_q <= pellets_d;
      lives_q   <= lives_d;
      dead_q    <= dead_d;
    end
  end

  assign score_bcd = score_q;
  assign pellets   = pellets_q;
  assign lives     = lives_q;
  assign dead      = dead_q;
  assign busy      = busy_q;
  assign scan_done = done_q;

endmodule
